// File: rtl/fft_burst_if.sv
// Handshake bundle between the FFT burst controller and its sample source,
// input buffer, compute core and output stage.
interface fft_burst_if #(
  parameter int unsigned ADDR_WIDTH = 9
) ();
  logic                  s_axi_valid;
  logic                  s_axi_last;
  logic                  s_axi_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  core_start;
  logic                  core_inverse;
  logic                  core_done;
  logic                  out_start;
  logic                  out_done;

  // Controller side
  modport master (
    input  s_axi_valid, s_axi_last, core_done, out_done,
    output s_axi_ready, wr_en, wr_addr, core_start, core_inverse, out_start
  );

  // Environment side (source, buffer, core, output stage)
  modport slave (
    output s_axi_valid, s_axi_last, core_done, out_done,
    input  s_axi_ready, wr_en, wr_addr, core_start, core_inverse, out_start
  );
endinterface

// File: rtl/fft_burst_ctrl.sv
// Burst sequencer for an FFT engine: loads N samples into the input buffer,
// kicks the compute core, then hands the result to the output stage.
module fft_burst_ctrl #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned MIN_POINTS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  soft_abort,
  input  logic [ADDR_WIDTH:0]   cfg_points,
  input  logic                  cfg_inverse,
  fft_burst_if.master           bus,
  output logic                  busy,
  output logic                  err_len,
  output logic [15:0]           burst_cnt
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] MIN_LEN    = CNT_W'(MIN_POINTS);
  localparam logic [CNT_W-1:0] MAX_POINTS = CNT_W'(2 ** ADDR_WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             inv_q, inv_d;
  logic             err_q, err_d;
  logic             core_start_q, core_start_d;
  logic             out_start_q, out_start_d;
  logic             busy_q, busy_d;
  logic [15:0]      burst_cnt_q, burst_cnt_d;

  logic             cfg_legal_c;
  logic             accept_c;
  logic             final_beat_c;

  // Legal lengths are powers of two within [MIN_POINTS, 2^ADDR_WIDTH]
  always_comb begin
    cfg_legal_c = (cfg_points >= MIN_LEN) && (cfg_points <= MAX_POINTS) &&
                  ((cfg_points & (cfg_points - CNT_W'(1))) == '0);
  end

  assign accept_c     = (state_q == LOAD) && bus.s_axi_valid;
  assign final_beat_c = (beat_q == (len_q - CNT_W'(1)));

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    beat_d       = beat_q;
    inv_d        = inv_q;
    err_d        = err_q;
    core_start_d = 1'b0;
    out_start_d  = 1'b0;
    burst_cnt_d  = burst_cnt_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          len_d = cfg_points;
          inv_d = cfg_inverse;
          if (cfg_legal_c) begin
            err_d   = 1'b0;
            beat_d  = '0;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept_c) begin
          beat_d = beat_q + CNT_W'(1);
          if (final_beat_c) begin
            state_d      = COMPUTE;
            core_start_d = 1'b1;
            if (!bus.s_axi_last) err_d = 1'b1;
          end else if (bus.s_axi_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      COMPUTE: begin
        if (bus.core_done) begin
          state_d     = DRAIN;
          out_start_d = 1'b1;
        end
      end
      DRAIN: begin
        if (bus.out_done) begin
          burst_cnt_d = burst_cnt_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything but keeps status and latched config
    if (soft_abort) begin
      state_d      = IDLE;
      beat_d       = '0;
      len_d        = len_q;
      inv_d        = inv_q;
      err_d        = err_q;
      core_start_d = 1'b0;
      out_start_d  = 1'b0;
      burst_cnt_d  = burst_cnt_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      beat_q       <= '0;
      inv_q        <= 1'b0;
      err_q        <= 1'b0;
      core_start_q <= 1'b0;
      out_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      inv_q        <= inv_d;
      err_q        <= err_d;
      core_start_q <= core_start_d;
      out_start_q  <= out_start_d;
      busy_q       <= busy_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  // Ready and write strobe decode the LOAD state so a beat lands the same cycle
  assign bus.s_axi_ready  = (state_q == LOAD);
  assign bus.wr_en        = accept_c;
  assign bus.wr_addr      = beat_q[ADDR_WIDTH-1:0];
  assign bus.core_start   = core_start_q;
  assign bus.core_inverse = inv_q;
  assign bus.out_start    = out_start_q;

  assign busy      = busy_q;
  assign err_len   = err_q;
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_fft_burst_ctrl.sv
// Directed bench for fft_burst_ctrl: one task per scenario, inline checks,
// pulse/write totals gathered by a negedge monitor.
module tb_fft_burst_ctrl;

  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          soft_abort;
  logic [AW:0]   cfg_points;
  logic          cfg_inverse;
  logic          busy;
  logic          err_len;
  logic [15:0]   burst_cnt;

  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  int cs_total = 0;
  int os_total = 0;

  fft_burst_if #(.ADDR_WIDTH(AW)) bus ();

  fft_burst_ctrl #(.ADDR_WIDTH(AW), .MIN_POINTS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .soft_abort  (soft_abort),
    .cfg_points  (cfg_points),
    .cfg_inverse (cfg_inverse),
    .bus         (bus),
    .busy        (busy),
    .err_len     (err_len),
    .burst_cnt   (burst_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1)      wr_total++;
    if (bus.core_start === 1'b1) cs_total++;
    if (bus.out_start === 1'b1)  os_total++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, sample the write strobe/address, then clock it in
  task automatic send_beat(input bit last, output logic we, output logic [AW-1:0] addr);
    bus.s_axi_valid = 1'b1;
    bus.s_axi_last  = last;
    #1;
    we   = bus.wr_en;
    addr = bus.wr_addr;
    @(posedge clk);
    #1;
    bus.s_axi_valid = 1'b0;
    bus.s_axi_last  = 1'b0;
  endtask

  task automatic start_burst(input logic [AW:0] n, input logic inv);
    cfg_points  = n;
    cfg_inverse = inv;
    enable      = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1; soft_abort = 1'b0; cfg_points = 10'd16; cfg_inverse = 1'b1;
    bus.s_axi_valid = 1'b0; bus.s_axi_last = 1'b0; bus.core_done = 1'b0; bus.out_done = 1'b0;
    repeat (2) tick();
    if ({bus.s_axi_ready, bus.wr_en, bus.core_start, bus.out_start, busy, err_len, bus.core_inverse} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000000",
        {bus.s_axi_ready, bus.wr_en, bus.core_start, bus.out_start, busy, err_len, bus.core_inverse});
    end
    checks++;
    if (bus.wr_addr !== 9'd0) begin errors++; $display("FAIL reset_wr_addr got %0d exp 0", bus.wr_addr); end
    checks++;
    if (burst_cnt !== 16'd0) begin errors++; $display("FAIL reset_burst_cnt got %0d exp 0", burst_cnt); end
    checks++;
    enable = 1'b0;
    rst_n  = 1'b1;
  endtask

  task automatic test_basic();
    int wr0 = wr_total, cs0 = cs_total, os0 = os_total;
    logic we; logic [AW-1:0] a;
    start_burst(10'd16, 1'b0);
    if ({busy, bus.s_axi_ready} !== 2'b11) begin errors++; $display("FAIL basic_load_entry got %b exp 11", {busy, bus.s_axi_ready}); end
    checks++;
    for (int i = 0; i < 16; i++) begin
      send_beat(i == 15, we, a);
      if (we !== 1'b1 || a !== 9'(i)) begin errors++; $display("FAIL basic_beat%0d got we=%b addr=%0d exp we=1 addr=%0d", i, we, a, i); end
      checks++;
    end
    if ({bus.core_start, bus.s_axi_ready} !== 2'b10) begin errors++; $display("FAIL basic_core_start got %b exp 10", {bus.core_start, bus.s_axi_ready}); end
    checks++;
    tick();
    if (bus.core_start !== 1'b0) begin errors++; $display("FAIL basic_core_start_width got %b exp 0", bus.core_start); end
    checks++;
    tick();
    bus.core_done = 1'b1; tick(); bus.core_done = 1'b0;
    if ({bus.out_start, busy} !== 2'b11) begin errors++; $display("FAIL basic_out_start got %b exp 11", {bus.out_start, busy}); end
    checks++;
    tick();
    if ({bus.out_start, burst_cnt} !== {1'b0, 16'd0}) begin errors++; $display("FAIL basic_drain_wait got os=%b cnt=%0d exp os=0 cnt=0", bus.out_start, burst_cnt); end
    checks++;
    bus.out_done = 1'b1; tick(); bus.out_done = 1'b0;
    if (burst_cnt !== 16'd1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done got cnt=%0d busy=%b exp cnt=1 busy=0", burst_cnt, busy); end
    checks++;
    if (wr_total - wr0 != 16 || cs_total - cs0 != 1 || os_total - os0 != 1) begin
      errors++; $display("FAIL basic_totals got wr=%0d cs=%0d os=%0d exp 16 1 1", wr_total - wr0, cs_total - cs0, os_total - os0);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    int os0 = os_total;
    logic we; logic [AW-1:0] a;
    bus.core_done = 1'b1; bus.out_done = 1'b1; tick();
    bus.core_done = 1'b0;
    if (busy !== 1'b0 || burst_cnt !== 16'd1) begin errors++; $display("FAIL b2b_idle_ignore got busy=%b cnt=%0d exp busy=0 cnt=1", busy, burst_cnt); end
    checks++;
    start_burst(10'd8, 1'b0);
    for (int i = 0; i < 8; i++) send_beat(i == 7, we, a);
    repeat (2) tick();
    bus.out_done = 1'b0;
    if (busy !== 1'b1 || burst_cnt !== 16'd1 || bus.s_axi_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_compute_ignore got busy=%b cnt=%0d rdy=%b exp busy=1 cnt=1 rdy=0", busy, burst_cnt, bus.s_axi_ready);
    end
    checks++;
    bus.core_done = 1'b1; tick();
    tick();
    bus.core_done = 1'b0;
    enable = 1'b1; cfg_points = 10'd8; bus.out_done = 1'b1; tick(); bus.out_done = 1'b0;
    if (busy !== 1'b0 || burst_cnt !== 16'd2) begin errors++; $display("FAIL b2b_gap got busy=%b cnt=%0d exp busy=0 cnt=2", busy, burst_cnt); end
    checks++;
    tick();
    enable = 1'b0;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart got busy=%b exp 1", busy); end
    checks++;
    soft_abort = 1'b1; tick(); soft_abort = 1'b0;
    if (busy !== 1'b0 || os_total - os0 != 1) begin errors++; $display("FAIL b2b_abort got busy=%b os=%0d exp busy=0 os=1", busy, os_total - os0); end
    checks++;
  endtask

  task automatic test_illegal_len();
    cfg_points = 10'd12; enable = 1'b1; tick();
    if ({err_len, busy} !== 2'b10) begin errors++; $display("FAIL illegal_12 got %b exp 10", {err_len, busy}); end
    checks++;
    cfg_points = 10'd4; tick();
    if ({err_len, busy} !== 2'b10) begin errors++; $display("FAIL illegal_4 got %b exp 10", {err_len, busy}); end
    checks++;
    cfg_points = 10'd1023; tick();
    if ({err_len, busy} !== 2'b10) begin errors++; $display("FAIL illegal_1023 got %b exp 10", {err_len, busy}); end
    checks++;
    cfg_points = 10'd8; tick();
    enable = 1'b0;
    if ({err_len, busy, bus.s_axi_ready} !== 3'b011) begin errors++; $display("FAIL illegal_recover got %b exp 011", {err_len, busy, bus.s_axi_ready}); end
    checks++;
    soft_abort = 1'b1; tick(); soft_abort = 1'b0;
    if (busy !== 1'b0 || burst_cnt !== 16'd2) begin errors++; $display("FAIL illegal_abort got busy=%b cnt=%0d exp busy=0 cnt=2", busy, burst_cnt); end
    checks++;
  endtask

  task automatic test_short_burst();
    int wr0 = wr_total, cs0 = cs_total;
    logic we; logic [AW-1:0] a;
    start_burst(10'd16, 1'b0);
    for (int i = 0; i < 10; i++) begin
      send_beat(i == 9, we, a);
      if (we !== 1'b1 || a !== 9'(i)) begin errors++; $display("FAIL short_beat%0d got we=%b addr=%0d exp we=1 addr=%0d", i, we, a, i); end
      checks++;
    end
    if ({busy, err_len} !== 2'b01) begin errors++; $display("FAIL short_status got %b exp 01", {busy, err_len}); end
    checks++;
    repeat (3) tick();
    if (wr_total - wr0 != 10 || cs_total - cs0 != 0) begin errors++; $display("FAIL short_totals got wr=%0d cs=%0d exp 10 0", wr_total - wr0, cs_total - cs0); end
    checks++;
  endtask

  task automatic test_long_burst();
    int wr0 = wr_total;
    logic we; logic [AW-1:0] a;
    start_burst(10'd8, 1'b0);
    if (err_len !== 1'b0) begin errors++; $display("FAIL long_err_clear got %b exp 0", err_len); end
    checks++;
    for (int i = 0; i < 8; i++) send_beat(1'b0, we, a);
    if ({bus.core_start, bus.s_axi_ready, err_len} !== 3'b101) begin
      errors++; $display("FAIL long_enter_compute got %b exp 101", {bus.core_start, bus.s_axi_ready, err_len});
    end
    checks++;
    send_beat(1'b0, we, a);
    if (we !== 1'b0) begin errors++; $display("FAIL long_backpressure got we=%b exp 0", we); end
    checks++;
    bus.core_done = 1'b1; tick(); bus.core_done = 1'b0;
    bus.out_done = 1'b1; tick(); bus.out_done = 1'b0;
    if (burst_cnt !== 16'd3 || err_len !== 1'b1 || wr_total - wr0 != 8) begin
      errors++; $display("FAIL long_done got cnt=%0d err=%b wr=%0d exp cnt=3 err=1 wr=8", burst_cnt, err_len, wr_total - wr0);
    end
    checks++;
  endtask

  task automatic test_abort_compute();
    int os0 = os_total;
    logic we; logic [AW-1:0] a;
    start_burst(10'd8, 1'b0);
    for (int i = 0; i < 8; i++) send_beat(i == 7, we, a);
    bus.core_done = 1'b1; soft_abort = 1'b1; tick();
    bus.core_done = 1'b0; soft_abort = 1'b0;
    if ({busy, bus.out_start} !== 2'b00) begin errors++; $display("FAIL abort_idle got %b exp 00", {busy, bus.out_start}); end
    checks++;
    repeat (2) tick();
    if (os_total - os0 != 0 || burst_cnt !== 16'd3 || err_len !== 1'b0) begin
      errors++; $display("FAIL abort_state got os=%0d cnt=%0d err=%b exp 0 3 0", os_total - os0, burst_cnt, err_len);
    end
    checks++;
  endtask

  task automatic test_random_512();
    int wr0 = wr_total;
    int sent = 0;
    int cyc = 0;
    logic we; logic [AW-1:0] a;
    start_burst(10'd512, 1'b1);
    cfg_inverse = 1'b0;
    cfg_points  = 10'd8;
    if (bus.core_inverse !== 1'b1) begin errors++; $display("FAIL rnd_inverse_latch got %b exp 1", bus.core_inverse); end
    checks++;
    while (sent < 512 && cyc < 5000) begin
      if ($urandom_range(0, 2) != 0) begin
        send_beat(sent == 511, we, a);
        if (we !== 1'b1 || a !== 9'(sent)) begin errors++; $display("FAIL rnd_beat%0d got we=%b addr=%0d exp we=1 addr=%0d", sent, we, a, sent); end
        checks++;
        sent++;
      end else begin
        tick();
      end
      cyc++;
    end
    if (sent != 512) begin errors++; $display("FAIL rnd_timeout got %0d beats exp 512", sent); end
    checks++;
    if ({bus.core_start, bus.core_inverse} !== 2'b11) begin errors++; $display("FAIL rnd_core_start got %b exp 11", {bus.core_start, bus.core_inverse}); end
    checks++;
    bus.core_done = 1'b1; tick(); bus.core_done = 1'b0;
    if ({bus.out_start, bus.core_inverse} !== 2'b11) begin errors++; $display("FAIL rnd_drain got %b exp 11", {bus.out_start, bus.core_inverse}); end
    checks++;
    bus.out_done = 1'b1; tick(); bus.out_done = 1'b0;
    if (burst_cnt !== 16'd4 || wr_total - wr0 != 512) begin
      errors++; $display("FAIL rnd_done got cnt=%0d wr=%0d exp cnt=4 wr=512", burst_cnt, wr_total - wr0);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    int cs0 = cs_total;
    logic we; logic [AW-1:0] a;
    start_burst(10'd16, 1'b1);
    for (int i = 0; i < 5; i++) send_beat(1'b0, we, a);
    bus.s_axi_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    if ({bus.s_axi_ready, bus.wr_en, bus.core_start, bus.out_start, busy, err_len, bus.core_inverse} !== 7'b0) begin
      errors++; $display("FAIL midrst_ctrl got %b exp 0000000",
        {bus.s_axi_ready, bus.wr_en, bus.core_start, bus.out_start, busy, err_len, bus.core_inverse});
    end
    checks++;
    if (bus.wr_addr !== 9'd0 || burst_cnt !== 16'd0) begin errors++; $display("FAIL midrst_regs got addr=%0d cnt=%0d exp 0 0", bus.wr_addr, burst_cnt); end
    checks++;
    bus.s_axi_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    start_burst(10'd8, 1'b0);
    send_beat(1'b0, we, a);
    if (we !== 1'b1 || a !== 9'd0) begin errors++; $display("FAIL midrst_restart got we=%b addr=%0d exp we=1 addr=0", we, a); end
    checks++;
    soft_abort = 1'b1; tick(); soft_abort = 1'b0;
    tick();
    if (cs_total - cs0 != 0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_pulses got cs=%0d busy=%b exp 0 0", cs_total - cs0, busy); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_illegal_len();
    test_short_burst();
    test_long_burst();
    test_abort_compute();
    test_random_512();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
